// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // State encodings, also visible on state_o
    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_LU_STALL   = 2'd1;
    localparam logic [1:0] ST_FETCH_WAIT = 2'd2;
    localparam logic [1:0] ST_HALT       = 2'd3;

    typedef enum logic [1:0] {
        RUN        = ST_RUN,
        LU_STALL   = ST_LU_STALL,
        FETCH_WAIT = ST_FETCH_WAIT,
        HALT       = ST_HALT
    } hz_state_t;

    // Register r0 is hard-wired to zero and never creates a dependency
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stick at all-ones, clear on request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// PC / pipeline-register sequencing controller: load-use stalls, branch
// flushes and variable-latency fetch with a timeout watchdog.
// Optional feature macro: HAZARD_PERF_EN (stall/flush performance counters).
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W    = 5,
    parameter int FETCH_TIMEOUT = 16,
    parameter int CNT_W         = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  idex_memread_i,
    input  logic [REG_ADDR_W-1:0] idex_rt_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs_i,
    input  logic [REG_ADDR_W-1:0] ifid_rt_i,
    input  logic                  branch_taken_i,
    input  logic                  imem_ready_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic                  exmem_flush_o,
    output logic [1:0]            state_o,
    output logic                  fetch_err_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    // FETCH_TIMEOUT is at most 255, so 8 bits always hold the wait count
    localparam int                WAIT_W     = 8;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(FETCH_TIMEOUT);

    hz_state_t         state;
    hz_state_t         state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              fetch_err;
    logic              fetch_err_next;
    logic              load_use;

    assign load_use = idex_memread_i
                   && (idex_rt_i != REG_ADDR_W'(REG_ZERO))
                   && ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

    // State register together with the fetch wait counter and sticky error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RUN;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_next;
            fetch_err <= fetch_err_next;
        end
    end

    // Next-state logic: HALT > branch > fetch miss > load-use > run
    always_comb begin
        state_next     = state;
        wait_next      = wait_cnt;
        fetch_err_next = fetch_err;
        if (state == HALT) begin
            state_next = HALT;
        end else if (branch_taken_i) begin
            state_next = RUN;
            wait_next  = '0;
        end else if (!imem_ready_i) begin
            if (wait_cnt != WAIT_LIMIT) begin
                wait_next = wait_cnt + WAIT_W'(1);
            end
            if (wait_next == WAIT_LIMIT) begin
                state_next     = HALT;
                fetch_err_next = 1'b1;
            end else begin
                state_next = FETCH_WAIT;
            end
        end else if (load_use && (state != LU_STALL)) begin
            // A stall cycle masks the check so stalls never chain
            state_next = LU_STALL;
            wait_next  = '0;
        end else begin
            state_next = RUN;
            wait_next  = '0;
        end
    end

    // Mealy strobes; reset forces a full bubble with PC and IF/ID frozen
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
        end else if (state == HALT) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
        end else if (!imem_ready_i) begin
            // Hold the PC, push a bubble into ID, let downstream drain
            pc_write_o   = 1'b0;
            ifid_flush_o = 1'b1;
        end else if (load_use && (state != LU_STALL)) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
        end
    end

    assign state_o     = state;
    assign fetch_err_o = fetch_err;

`ifdef HAZARD_PERF_EN
    logic stall_inc;
    logic flush_inc;

    // HALT cycles are a fault condition, not a pipeline stall
    assign stall_inc = !pc_write_o && (state != HALT);
    assign flush_inc = branch_taken_i && (state != HALT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (1'b0),
        .inc   (stall_inc),
        .count (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (1'b0),
        .inc   (flush_inc),
        .count (flush_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller with a behavioural reference model.
`timescale 1ns/1ps
module tb_hazard_controller;

    localparam int RW  = 5;
    localparam int TMO = 16;
    localparam int CW  = 32;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic          idex_memread_i;
    logic [RW-1:0] idex_rt_i;
    logic [RW-1:0] ifid_rs_i;
    logic [RW-1:0] ifid_rt_i;
    logic          branch_taken_i;
    logic          imem_ready_i;
    logic          pc_write_o;
    logic          ifid_write_o;
    logic          ifid_flush_o;
    logic          idex_flush_o;
    logic          exmem_flush_o;
    logic [1:0]    state_o;
    logic          fetch_err_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;

    always #5 clk = ~clk;

    hazard_controller #(
        .REG_ADDR_W    (RW),
        .FETCH_TIMEOUT (TMO),
        .CNT_W         (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .branch_taken_i (branch_taken_i),
        .imem_ready_i   (imem_ready_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_flush_o   (idex_flush_o),
        .exmem_flush_o  (exmem_flush_o),
        .state_o        (state_o),
        .fetch_err_o    (fetch_err_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pipeline situation tracked as plain integers
    int            m_state;   // 0 run, 1 after stall, 2 waiting on fetch, 3 halted
    int            m_wait;    // consecutive not-ready cycles
    bit            m_err;
    logic [CW-1:0] m_stall;
    logic [CW-1:0] m_flush;
    logic [4:0]    exp_out;   // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}
    logic [CW-1:0] exp_stall;
    logic [CW-1:0] exp_flush;
    wire  [4:0]    act_out = {pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, exmem_flush_o};

    function automatic bit hazard_now();
        return idex_memread_i && (idex_rt_i != 0)
            && ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_wait  = 0;
        m_err   = 1'b0;
        m_stall = '0;
        m_flush = '0;
        exp_stall = '0;
        exp_flush = '0;
    endtask

    // Drive one cycle of inputs and derive the expected strobes
    task automatic apply(input bit mr, input int ldr, input int rs, input int rt,
                         input bit br, input bit rdy);
        idex_memread_i = mr;
        idex_rt_i      = RW'(ldr);
        ifid_rs_i      = RW'(rs);
        ifid_rt_i      = RW'(rt);
        branch_taken_i = br;
        imem_ready_i   = rdy;
        if (m_state == 3)                        exp_out = 5'b00010;
        else if (br)                             exp_out = 5'b10111;
        else if (!rdy)                           exp_out = 5'b01100;
        else if (hazard_now() && m_state != 1)   exp_out = 5'b00010;
        else                                     exp_out = 5'b11000;
        #2;
    endtask

    // Advance the model across one rising edge, then settle
    task automatic clock_edge();
        bit lu;
        lu = hazard_now();
        if (m_state != 3) begin
            if (!exp_out[4] && m_stall != '1) m_stall = m_stall + 1;
            if (branch_taken_i) begin
                if (m_flush != '1) m_flush = m_flush + 1;
                m_state = 0;
                m_wait  = 0;
            end else if (!imem_ready_i) begin
                m_wait = (m_wait < TMO) ? m_wait + 1 : TMO;
                if (m_wait == TMO) begin
                    m_state = 3;
                    m_err   = 1'b1;
                end else begin
                    m_state = 2;
                end
            end else if (lu && m_state != 1) begin
                m_state = 1;
                m_wait  = 0;
            end else begin
                m_state = 0;
                m_wait  = 0;
            end
        end
        exp_stall = PERF ? m_stall : '0;
        exp_flush = PERF ? m_flush : '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (act_out !== 5'b00111) begin n_fail++; $display("FAIL reset_out: got %b want %b", act_out, 5'b00111); end
        n_checks++;
        if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
        n_checks++;
        if (fetch_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fetch_err_o); end
        n_checks++;
        if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
        #1;
        $display("reset released: state=%0d out=%b", state_o, act_out);
    endtask

    task automatic test_load_use();
        for (int k = 0; k < 2; k++) begin
            apply(1, 8, 8, 3, 0, 1);
            n_checks++;
            if (act_out !== exp_out) begin n_fail++; $display("FAIL load_use_out%0d: got %b want %b", k, act_out, exp_out); end
            clock_edge();
            n_checks++;
            if (state_o !== 2'(m_state)) begin n_fail++; $display("FAIL load_use_state%0d: got %0d want %0d", k, state_o, m_state); end
            $display("load_use cycle %0d: out=%b state=%0d", k, act_out, state_o);
        end
    endtask

    task automatic test_rt_zero();
        apply(1, 0, 5, 0, 0, 1);
        n_checks++;
        if (act_out !== exp_out) begin n_fail++; $display("FAIL rt_zero_out: got %b want %b", act_out, exp_out); end
        clock_edge();
        n_checks++;
        if (state_o !== 2'(m_state)) begin n_fail++; $display("FAIL rt_zero_state: got %0d want %0d", state_o, m_state); end
        $display("rt_zero: out=%b state=%0d", act_out, state_o);
    endtask

    task automatic test_branch_lu();
        apply(1, 8, 8, 1, 1, 1);
        n_checks++;
        if (act_out !== exp_out) begin n_fail++; $display("FAIL branch_lu_out: got %b want %b", act_out, exp_out); end
        clock_edge();
        n_checks++;
        if (state_o !== 2'(m_state)) begin n_fail++; $display("FAIL branch_lu_state: got %0d want %0d", state_o, m_state); end
        n_checks++;
        if (flush_cnt_o !== exp_flush) begin n_fail++; $display("FAIL branch_lu_flushcnt: got %0d want %0d", flush_cnt_o, exp_flush); end
        $display("branch_lu: state=%0d flush_cnt=%0d", state_o, flush_cnt_o);
    endtask

    task automatic test_fetch_recover();
        for (int k = 0; k < 4; k++) begin
            apply(0, 0, 0, 0, 0, (k == 3));
            n_checks++;
            if (act_out !== exp_out) begin n_fail++; $display("FAIL fetch_rec_out%0d: got %b want %b", k, act_out, exp_out); end
            clock_edge();
            n_checks++;
            if (state_o !== 2'(m_state)) begin n_fail++; $display("FAIL fetch_rec_state%0d: got %0d want %0d", k, state_o, m_state); end
            n_checks++;
            if (fetch_err_o !== m_err) begin n_fail++; $display("FAIL fetch_rec_err%0d: got %b want %b", k, fetch_err_o, m_err); end
            $display("fetch_recover cycle %0d: out=%b state=%0d err=%b", k, act_out, state_o, fetch_err_o);
        end
        n_checks++;
        if (stall_cnt_o !== exp_stall) begin n_fail++; $display("FAIL fetch_rec_stallcnt: got %0d want %0d", stall_cnt_o, exp_stall); end
    endtask

    task automatic test_random(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            apply($urandom % 2, $urandom % 4, $urandom % 4, $urandom % 4,
                  ($urandom % 8) == 0, ($urandom % 4) != 0);
            n_checks++;
            if (act_out !== exp_out) begin n_fail++; $display("FAIL rand_out%0d: got %b want %b", k, act_out, exp_out); end
            clock_edge();
            n_checks++;
            if (state_o !== 2'(m_state) || fetch_err_o !== m_err) begin
                n_fail++; $display("FAIL rand_state%0d: got %0d/%b want %0d/%b", k, state_o, fetch_err_o, m_state, m_err);
            end
            n_checks++;
            if (stall_cnt_o !== exp_stall || flush_cnt_o !== exp_flush) begin
                n_fail++; $display("FAIL rand_cnt%0d: got %0d/%0d want %0d/%0d", k, stall_cnt_o, flush_cnt_o, exp_stall, exp_flush);
            end
            $display("rand %0d: out=%b state=%0d", k, act_out, state_o);
        end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < TMO; k++) begin
            apply(0, 0, 0, 0, 0, 0);
            n_checks++;
            if (act_out !== exp_out) begin n_fail++; $display("FAIL timeout_out%0d: got %b want %b", k, act_out, exp_out); end
            clock_edge();
            n_checks++;
            if (state_o !== 2'(m_state) || fetch_err_o !== m_err) begin
                n_fail++; $display("FAIL timeout_state%0d: got %0d/%b want %0d/%b", k, state_o, fetch_err_o, m_state, m_err);
            end
            $display("timeout cycle %0d: state=%0d err=%b", k, state_o, fetch_err_o);
        end
        n_checks++;
        if (fetch_err_o !== 1'b1 || state_o !== 2'd3) begin
            n_fail++; $display("FAIL timeout_halt: got err=%b state=%0d want err=1 state=3", fetch_err_o, state_o);
        end
        // Branch cannot leave HALT
        apply(0, 0, 0, 0, 1, 1);
        n_checks++;
        if (act_out !== exp_out) begin n_fail++; $display("FAIL halt_branch_out: got %b want %b", act_out, exp_out); end
        clock_edge();
        n_checks++;
        if (state_o !== 2'(m_state)) begin n_fail++; $display("FAIL halt_branch_state: got %0d want %0d", state_o, m_state); end
        // Asynchronous reset clears HALT without a clock edge
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (state_o !== 2'd0 || fetch_err_o !== 1'b0 || act_out !== 5'b00111) begin
            n_fail++; $display("FAIL halt_async_rst: got state=%0d err=%b out=%b want 0/0/00111", state_o, fetch_err_o, act_out);
        end
        $display("halt reset: state=%0d err=%b", state_o, fetch_err_o);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        for (int k = 0; k < 3; k++) begin
            apply(1, 8, 8, 8, 0, 0);
            clock_edge();
        end
        n_checks++;
        if (state_o !== 2'(m_state)) begin n_fail++; $display("FAIL midwait_pre_state: got %0d want %0d", state_o, m_state); end
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (state_o !== 2'd0 || pc_write_o !== 1'b0 || stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
            n_fail++; $display("FAIL midwait_async_rst: got state=%0d pc=%b cnt=%0d/%0d want 0/0/0/0",
                               state_o, pc_write_o, stall_cnt_o, flush_cnt_o);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        apply(0, 0, 0, 0, 0, 1);
        n_checks++;
        if (state_o !== 2'd0 || act_out !== exp_out) begin
            n_fail++; $display("FAIL midwait_first_run: got state=%0d out=%b want 0/%b", state_o, act_out, exp_out);
        end
        clock_edge();
        n_checks++;
        if (state_o !== 2'(m_state)) begin n_fail++; $display("FAIL midwait_after: got %0d want %0d", state_o, m_state); end
        $display("reset mid-wait: state=%0d out=%b", state_o, act_out);
    endtask

    initial begin
        rst_i          = 1'b1;
        idex_memread_i = 1'b0;
        idex_rt_i      = '0;
        ifid_rs_i      = '0;
        ifid_rt_i      = '0;
        branch_taken_i = 1'b0;
        imem_ready_i   = 1'b1;
        model_reset();
        exp_out = 5'b11000;
        test_reset();
        test_load_use();
        test_rt_zero();
        test_branch_lu();
        test_fetch_recover();
        test_random(200);
        test_reset_mid_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Sequencing controller for the pipelined CPU's program counter and IF/ID, ID/EX and EX/MEM pipeline registers. It generates `pc_write`, the IF/ID write enable and the per-stage flush strobes. Three sources drive it:
- load-use data hazards,
- taken branches resolved in MEM,
- a variable-latency instruction fetch, with a timeout watchdog.

It sits beside the hazard-free datapath and drives the enables of the PC and the pipeline registers directly.

## Interface
Parameters:
- `REG_ADDR_W`, 5: register-specifier width.
- `FETCH_TIMEOUT`, 16: consecutive not-ready fetch cycles that trigger HALT (legal range 2..255).
- `CNT_W`, 32: performance counter width.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset; asynchronous, active-high.
- `idex_memread_i` in 1: instruction in EX is a load.
- `idex_rt_i` in `REG_ADDR_W`: load destination register.
- `ifid_rs_i`, `ifid_rt_i` in `REG_ADDR_W`: source registers of the instruction in ID.
- `branch_taken_i` in 1: taken branch resolved in MEM this cycle.
- `imem_ready_i` in 1: instruction memory returns valid data this cycle.
- `pc_write_o` out 1: PC load enable.
- `ifid_write_o` out 1: IF/ID load enable.
- `ifid_flush_o`, `idex_flush_o`, `exmem_flush_o` out 1: force a bubble into that register.
- `state_o` out 2: current FSM state.
- `fetch_err_o` out 1: sticky fetch-timeout flag.
- `stall_cnt_o`, `flush_cnt_o` out `CNT_W`: performance counters.

## Operation
States:
- RUN = 0
- LU_STALL = 1
- FETCH_WAIT = 2
- HALT = 3

Strobes are Mealy outputs, combinational from state and inputs, valid in the same cycle.

Load-use hazard, defined as `idex_memread_i` && `idex_rt_i` != 0 && (`idex_rt_i` == `ifid_rs_i` || `idex_rt_i` == `ifid_rt_i`).

Default in RUN with no event: `pc_write_o` = 1, `ifid_write_o` = 1, all flushes = 0.

Priority per cycle, highest first:
1. HALT: `pc_write_o` = 0, `ifid_write_o` = 0, `idex_flush_o` = 1. The state holds until reset.
2. `branch_taken_i`, in any non-HALT state:
   - outputs: `pc_write_o` = 1, `ifid_write_o` = 0, `ifid_flush_o` = `idex_flush_o` = `exmem_flush_o` = 1;
   - the fetch wait counter clears and the next state is RUN.
3. `imem_ready_i` = 0:
   - outputs: `pc_write_o` = 0, `ifid_write_o` = 1, `ifid_flush_o` = 1 (bubble into ID); downstream stages advance;
   - next state is FETCH_WAIT; the wait counter increments, saturating at `FETCH_TIMEOUT`;
   - when the counter reaches `FETCH_TIMEOUT`, the next state is HALT and `fetch_err_o` sets.
4. Load-use hazard while in RUN:
   - outputs: `pc_write_o` = 0, `ifid_write_o` = 0, `idex_flush_o` = 1;
   - next state is LU_STALL.
5. Otherwise: default outputs and the next state is RUN.

State-specific rules:
- In LU_STALL, the load-use check is masked for that single cycle, so a stall never chains.
- In FETCH_WAIT with `imem_ready_i` = 1, the counter clears and the load-use check applies as in RUN.

## Timing
- Reset, asynchronous, takes effect immediately:
  - state = RUN, wait counter = 0, `fetch_err_o` = 0, counters = 0;
  - while `rst_i` is high: `pc_write_o` = 0, `ifid_write_o` = 0, all flushes = 1.
- Reset asserted mid-stall or mid-wait aborts the operation; the first cycle after deassertion is RUN.
- A load-use stall costs exactly 1 cycle; the dependent instruction reaches EX 2 cycles after the load.
- A branch flush costs 3 bubbles; the target is fetched in the cycle after `branch_taken_i`.
- Simultaneous events:
  - branch with imem not ready: the branch wins;
  - branch with load-use: the branch wins;
  - imem not ready with load-use: the fetch stall wins, and the hazard is re-evaluated next cycle.
- `fetch_err_o` asserts on the edge where the wait counter reaches `FETCH_TIMEOUT`, and is registered.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_cnt_o` increments every cycle with `pc_write_o` = 0 outside reset, excluding HALT;
  - `flush_cnt_o` increments on each cycle with `branch_taken_i` accepted;
  - both counters saturate at all-ones.
- `HAZARD_PERF_EN` undefined: both outputs are tied to 0 and no counter flops exist. The ports are present either way.

## Structure
- Shared package `hazard_pkg`:
  - state enum `hz_state_t` (RUN/LU_STALL/FETCH_WAIT/HALT);
  - constant `REG_ZERO` = 0;
  - state encoding constants.
- Sub-module `sat_counter` (width parameter, increment enable, synchronous clear, asynchronous reset), instantiated twice under `HAZARD_PERF_EN`.

## Test plan
- Load-use stall:
  - stimulus: `idex_memread_i` = 1, `idex_rt_i` = 8, `ifid_rs_i` = 8, imem ready;
  - response: one cycle with `pc_write_o` = 0, `ifid_write_o` = 0, `idex_flush_o` = 1 and `state_o` = 1;
  - holding the inputs a second cycle gives no further stall.
- `idex_rt_i` = 0 with matching `ifid_rt_i` = 0 and memread = 1: no stall, RUN defaults.
- Branch with load-use in the same cycle: all three flushes = 1, `pc_write_o` = 1, next `state_o` = 0, `flush_cnt_o` +1.
- Fetch stall then recovery: `imem_ready_i` = 0 for 3 cycles then 1 → `pc_write_o` = 0 and `ifid_flush_o` = 1 for 3 cycles, then RUN, no error.
- Fetch timeout: `imem_ready_i` = 0 for 16 cycles → `fetch_err_o` = 1 and `state_o` = 3. HALT holds despite `branch_taken_i` = 1; `rst_i` clears it asynchronously.
- Asynchronous reset asserted mid-FETCH_WAIT between clock edges → immediately `state_o` = 0, counters = 0, `pc_write_o` = 0.
